// File: rtl/sbox_share_arbiter_if.sv
// Byte request lanes (state, key) and the tagged response bus around the shared S-box.
interface sbox_share_arbiter_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_enc;
    logic       k_valid;
    logic       k_ready;
    logic [7:0] k_data;
    logic       k_enc;
    logic       rsp_valid;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       busy;

    modport master (
        output s_valid, s_data, s_enc, k_valid, k_data, k_enc,
        input  s_ready, k_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  s_valid, s_data, s_enc, k_valid, k_data, k_enc,
        output s_ready, k_ready, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/sbox_share_arbiter.sv
// Round-robin share of one AES S-box between the state and key-schedule byte lanes.
// Define SBOX_SPLIT_PIPE_EN to register the GF(2^4) inverter output (latency 2 -> 3 edges).
module sbox_share_arbiter #(
    parameter logic KEY_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    sbox_share_arbiter_if.slave bus
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        return a ^ rotl(a, 1) ^ rotl(a, 2) ^ rotl(a, 3) ^ rotl(a, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        return rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
    endfunction

    logic       ptr_q, ptr_d;
    logic       s_grant, k_grant;
    logic       s0_valid_q, s0_valid_d, s0_id_q, s0_id_d, s0_enc_q, s0_enc_d;
    logic [7:0] s0_data_q, s0_data_d;
    logic       rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic [7:0] inv_in, x2, x4, x8, x16, norm, n2, n4, n8, norm_inv, prod;
    logic       out_valid, out_id, out_enc;
    logic [7:0] mul_a, mul_b;

    always_comb begin
        s_grant = bus.s_valid & ~clr & ~rst & (~bus.k_valid | ~ptr_q);
        k_grant = bus.k_valid & ~clr & ~rst & (~bus.s_valid | ptr_q);
        // A contested grant hands priority to the loser for the next contest.
        ptr_d = ptr_q;
        if (clr) ptr_d = KEY_FIRST;
        else if (bus.s_valid & bus.k_valid) ptr_d = ~ptr_q;
        s0_valid_d = s_grant | k_grant;
        s0_id_d    = k_grant;
        s0_enc_d   = s0_enc_q;
        s0_data_d  = s0_data_q;
        if (k_grant) begin
            s0_enc_d  = bus.k_enc;
            s0_data_d = bus.k_data;
        end else if (s_grant) begin
            s0_enc_d  = bus.s_enc;
            s0_data_d = bus.s_data;
        end
    end

    // x^-1 = x^16 * (x^17)^-1; x^17 lies in the GF(2^4) subfield where n^-1 = n^14.
    always_comb begin
        inv_in   = s0_enc_q ? s0_data_q : inv_affine(s0_data_q);
        x2       = gf_mul(inv_in, inv_in);
        x4       = gf_mul(x2, x2);
        x8       = gf_mul(x4, x4);
        x16      = gf_mul(x8, x8);
        norm     = gf_mul(x16, inv_in);
        n2       = gf_mul(norm, norm);
        n4       = gf_mul(n2, n2);
        n8       = gf_mul(n4, n4);
        norm_inv = gf_mul(gf_mul(n2, n4), n8);
    end

`ifdef SBOX_SPLIT_PIPE_EN
    logic       s1_valid_q, s1_valid_d, s1_id_q, s1_enc_q;
    logic [7:0] s1_ninv_q, s1_x16_q;

    always_comb begin
        s1_valid_d = s0_valid_q & ~clr;
        out_valid  = s1_valid_q;
        out_id     = s1_id_q;
        out_enc    = s1_enc_q;
        mul_a      = s1_ninv_q;
        mul_b      = s1_x16_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= 1'b0;
            s1_enc_q   <= 1'b0;
            s1_ninv_q  <= 8'h00;
            s1_x16_q   <= 8'h00;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s0_id_q;
            s1_enc_q   <= s0_enc_q;
            s1_ninv_q  <= norm_inv;
            s1_x16_q   <= x16;
        end
    end

    assign bus.busy = s0_valid_q | s1_valid_q | rsp_valid_q;
`else
    always_comb begin
        out_valid = s0_valid_q;
        out_id    = s0_id_q;
        out_enc   = s0_enc_q;
        mul_a     = norm_inv;
        mul_b     = x16;
    end

    assign bus.busy = s0_valid_q | rsp_valid_q;
`endif

    always_comb begin
        prod        = gf_mul(mul_a, mul_b);
        rsp_valid_d = out_valid & ~clr;
        rsp_id_d    = out_id;
        rsp_data_d  = out_enc ? affine(prod) : prod;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= KEY_FIRST;
            s0_valid_q  <= 1'b0;
            s0_id_q     <= 1'b0;
            s0_enc_q    <= 1'b0;
            s0_data_q   <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            ptr_q       <= ptr_d;
            s0_valid_q  <= s0_valid_d;
            s0_id_q     <= s0_id_d;
            s0_enc_q    <= s0_enc_d;
            s0_data_q   <= s0_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.s_ready   = s_grant;
    assign bus.k_ready   = k_grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Directed bench for sbox_share_arbiter: scoreboard of expected {id, byte, accept time}.
module tb_sbox_share_arbiter;

`ifdef SBOX_SPLIT_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         t;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    sbox_share_arbiter_if bus ();

    sbox_share_arbiter #(.KEY_FIRST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic s_fired, k_fired;

    logic [7:0] s_list [8] = '{8'h00, 8'h53, 8'h01, 8'h10, 8'h11, 8'h20, 8'h55, 8'hAA};
    logic [7:0] k_list [8] = '{8'h02, 8'h03, 8'hFF, 8'h10, 8'h53, 8'h00, 8'h01, 8'hAA};

    // Known AES S-box / inverse S-box pairs for every byte the bench sends.
    function automatic logic [7:0] ref_sub(input logic [7:0] d, input logic enc);
        logic [7:0] r;
        r = 8'hxx;
        if (enc) begin
            case (d)
                8'h00: r = 8'h63; 8'h01: r = 8'h7C; 8'h02: r = 8'h77; 8'h03: r = 8'h7B;
                8'h10: r = 8'hCA; 8'h11: r = 8'h82; 8'h20: r = 8'hB7; 8'h53: r = 8'hED;
                8'h55: r = 8'hFC; 8'hAA: r = 8'hAC; 8'hFF: r = 8'h16;
                default: r = 8'hxx;
            endcase
        end else begin
            case (d)
                8'h63: r = 8'h00; 8'h7C: r = 8'h01; 8'h77: r = 8'h02; 8'h7B: r = 8'h03;
                8'hCA: r = 8'h10; 8'h82: r = 8'h11; 8'hB7: r = 8'h20; 8'hED: r = 8'h53;
                8'hFC: r = 8'h55; 8'hAC: r = 8'hAA; 8'h16: r = 8'hFF;
                default: r = 8'hxx;
            endcase
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_s(input logic v, input logic [7:0] d, input logic e);
        bus.s_valid = v;
        bus.s_data  = d;
        bus.s_enc   = e;
    endtask

    task automatic set_k(input logic v, input logic [7:0] d, input logic e);
        bus.k_valid = v;
        bus.k_data  = d;
        bus.k_enc   = e;
    endtask

    // One clock: sample handshakes and responses on the falling edge, then advance.
    task automatic cycle();
        sb_t e;
        @(negedge clk);
        s_fired = bus.s_valid & bus.s_ready;
        k_fired = bus.k_valid & bus.k_ready;
        if (s_fired) sb.push_back('{1'b0, ref_sub(bus.s_data, bus.s_enc), cyc});
        if (k_fired) sb.push_back('{1'b1, ref_sub(bus.k_data, bus.k_enc), cyc});
        if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected_queue_size", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("rsp_id", {31'd0, bus.rsp_id}, {31'd0, e.id});
                check("rsp_data", {24'd0, bus.rsp_data}, {24'd0, e.data});
                check("rsp_latency", 32'(cyc - e.t), 32'(LAT));
                $display("t=%0t rsp id=%0d data=%02h exp_id=%0d exp_data=%02h lat=%0d",
                         $time, bus.rsp_id, bus.rsp_data, e.id, e.data, cyc - e.t);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int n;
        set_s(1'b0, 8'h00, 1'b1);
        set_k(1'b0, 8'h00, 1'b1);
        n = 0;
        while ((bus.busy || sb.size() != 0) && n < 30) begin
            cycle();
            n++;
        end
        cycle();
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
        check("drain_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int si, ki;
        logic exp_k;
        logic kv_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic kg_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        set_s(1'b1, s_list[0], 1'b1);
        set_k(1'b1, k_list[0], 1'b1);
        @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
        check("rst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        check("rst_k_ready", {31'd0, bus.k_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("first_grant_k_ready", {31'd0, bus.k_ready}, 32'd1);
        check("first_grant_s_ready", {31'd0, bus.s_ready}, 32'd0);

        // Continuous contention: K, S, K, S ...
        si = 0;
        ki = 0;
        exp_k = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_s(1'b1, s_list[si % 8], 1'b1);
            set_k(1'b1, k_list[ki % 8], 1'b1);
            cycle();
            $display("t=%0t contend cycle %0d grant_k=%0d grant_s=%0d", $time, i, k_fired, s_fired);
            check("contend_grant_k", {31'd0, k_fired}, {31'd0, exp_k});
            exp_k = ~exp_k;
            if (s_fired) si++;
            if (k_fired) ki++;
        end
        check("contend_s_count", 32'(si), 32'd4);
        drain();

        // State lane only, forward S-box, back-to-back.
        for (int i = 0; i < 3; i++) begin
            set_s(1'b1, s_list[i], 1'b1);
            cycle();
            check("s_only_grant", {31'd0, s_fired}, 32'd1);
        end
        drain();

        // Key lane only, inverse S-box.
        set_k(1'b1, 8'h63, 1'b0);
        cycle();
        check("k_only_grant0", {31'd0, k_fired}, 32'd1);
        set_k(1'b1, 8'h16, 1'b0);
        cycle();
        check("k_only_grant1", {31'd0, k_fired}, 32'd1);
        drain();

        // Key drops valid mid-stream; pointer must not move on uncontested grants.
        si = 3;
        ki = 3;
        for (int i = 0; i < 6; i++) begin
            set_s(1'b1, s_list[si % 8], (i % 2) == 0);
            set_k(kv_pat[i], k_list[ki % 8], 1'b1);
            if ((i % 2) != 0) set_s(1'b1, ref_sub(s_list[si % 8], 1'b1), 1'b0);
            cycle();
            $display("t=%0t drop cycle %0d grant_k=%0d grant_s=%0d", $time, i, k_fired, s_fired);
            check("drop_grant_k", {31'd0, k_fired}, {31'd0, kg_pat[i]});
            check("drop_grant_s", {31'd0, s_fired}, {31'd0, ~kg_pat[i]});
            if (s_fired) si++;
            if (k_fired) ki++;
        end
        drain();

        // Flush with bytes in flight; pointer currently favours state.
        set_s(1'b1, 8'h00, 1'b1);
        cycle();
        set_s(1'b1, 8'h01, 1'b1);
        cycle();
        clr = 1'b1;
        set_s(1'b1, 8'h02, 1'b1);
        set_k(1'b1, 8'h03, 1'b1);
        #1;
        check("clr_s_ready", {31'd0, bus.s_ready}, 32'd0);
        check("clr_k_ready", {31'd0, bus.k_ready}, 32'd0);
        cycle();
        sb.delete();
        check("clr_busy", {31'd0, bus.busy}, 32'd0);
        clr = 1'b0;
        #1;
        check("clr_ptr_k_ready", {31'd0, bus.k_ready}, 32'd1);
        check("clr_ptr_s_ready", {31'd0, bus.s_ready}, 32'd0);
        cycle();
        check("post_clr_grant_k", {31'd0, k_fired}, 32'd1);
        drain();

        // Asynchronous reset mid-stream.
        set_s(1'b1, 8'h53, 1'b1);
        cycle();
        set_s(1'b1, 8'h55, 1'b1);
        cycle();
        set_s(1'b1, 8'hAA, 1'b1);
        cycle();
        set_s(1'b0, 8'h00, 1'b1);
        check("pre_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("async_rst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
        check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        sb.delete();
        cycle();
        rst = 1'b0;
        set_s(1'b1, 8'hFF, 1'b1);
        cycle();
        check("post_rst_grant_s", {31'd0, s_fired}, 32'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
